decrypt_round_serial: RTL

Byte-serial AES inverse-round datapath; the decrypt-side counterpart of the byte-serial encrypt round.
- Accepts a 16-byte state one byte per cycle, in column-major order (byte index i = row + 4*col).
- Applies InvMixColumns (skippable for the final round), then InvShiftRows and InvSubBytes, and streams 16 result bytes out with valid/ready handshakes.
- Feeding it the output of one encrypt round (ShiftRows, SubBytes, MixColumns) returns the original state.

---
 rtl/decrypt_round_serial.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/decrypt_round_serial.sv
// Byte-serial AES inverse round: load 16 bytes, optional InvMixColumns, then stream InvShiftRows+InvSubBytes.
// Optional build macro DECRYPT_ROUND_KEY_EN adds key_data and XORs it into each loaded byte.
module decrypt_round_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
`ifdef DECRYPT_ROUND_KEY_EN
  input  logic [7:0] key_data,
`endif
  input  logic       skip_mc,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [1:0] {LOAD, MIX, OUT} state_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant: each set bit of c selects a, 2a, 4a or 8a.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] a2, a4, a8;
    a2 = xtime(a);
    a4 = xtime(a2);
    a8 = xtime(a4);
    return (c[0] ? a : 8'h00) ^ (c[1] ? a2 : 8'h00) ^
           (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[x];
  endfunction

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] col_q, col_d;
  logic       skip_q, skip_d;
  logic [7:0] state_buf [16];

  logic       load_we, mix_we;
  logic [7:0] load_byte;
  logic [7:0] col_in  [4];
  logic [7:0] col_out [4];
  logic [1:0] src_col;

`ifdef DECRYPT_ROUND_KEY_EN
  assign load_byte = in_data ^ key_data;
`else
  assign load_byte = in_data;
`endif

  // Control registers: rst clears asynchronously, flush clears at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= 4'd0;
      col_q   <= 2'd0;
      skip_q  <= 1'b0;
    end else if (flush) begin
      state_q <= LOAD;
      cnt_q   <= 4'd0;
      col_q   <= 2'd0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    skip_d    = skip_q;
    load_we   = 1'b0;
    mix_we    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_we = 1'b1;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd0) skip_d = skip_mc;
          // skip_q already holds the value captured with byte 0.
          if (cnt_q == 4'd15) state_d = skip_q ? OUT : MIX;
        end
      end
      MIX: begin
        mix_we = 1'b1;
        col_d  = col_q + 2'd1;
        if (col_q == 2'd3) state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // InvMixColumns on the column selected by col_q, written back in place.
  always_comb begin
    col_in[0] = state_buf[{col_q, 2'd0}];
    col_in[1] = state_buf[{col_q, 2'd1}];
    col_in[2] = state_buf[{col_q, 2'd2}];
    col_in[3] = state_buf[{col_q, 2'd3}];
    col_out[0] = gmul(col_in[0], 4'he) ^ gmul(col_in[1], 4'hb) ^
                 gmul(col_in[2], 4'hd) ^ gmul(col_in[3], 4'h9);
    col_out[1] = gmul(col_in[0], 4'h9) ^ gmul(col_in[1], 4'he) ^
                 gmul(col_in[2], 4'hb) ^ gmul(col_in[3], 4'hd);
    col_out[2] = gmul(col_in[0], 4'hd) ^ gmul(col_in[1], 4'h9) ^
                 gmul(col_in[2], 4'he) ^ gmul(col_in[3], 4'hb);
    col_out[3] = gmul(col_in[0], 4'hb) ^ gmul(col_in[1], 4'hd) ^
                 gmul(col_in[2], 4'h9) ^ gmul(col_in[3], 4'he);
  end

  always_ff @(posedge clk) begin
    if (load_we) begin
      state_buf[cnt_q] <= load_byte;
    end else if (mix_we) begin
      state_buf[{col_q, 2'd0}] <= col_out[0];
      state_buf[{col_q, 2'd1}] <= col_out[1];
      state_buf[{col_q, 2'd2}] <= col_out[2];
      state_buf[{col_q, 2'd3}] <= col_out[3];
    end
  end

  // InvShiftRows is folded into the read address: row r comes from column (c - r) mod 4.
  assign src_col  = cnt_q[3:2] - cnt_q[1:0];
  assign out_data = out_valid ? inv_sbox(state_buf[{src_col, cnt_q[1:0]}]) : 8'h00;
  assign busy     = (state_q != LOAD) || (cnt_q != 4'd0);

endmodule
